// File: rtl/rvpc_mmu_pkg.sv
// Shared MMU definitions: walker FSM states, PTE bit positions and satp fields.
package rvpc_mmu_pkg;

  typedef enum logic [1:0] {
    PTW_IDLE = 2'd0,
    PTW_L1   = 2'd1,
    PTW_L0   = 2'd2,
    PTW_RESP = 2'd3
  } ptw_state_e;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;
  localparam int PTE_PPN_LSB = 10;

  localparam int SATP_MODE_BIT = 31;
  localparam int PAGE_SHIFT    = 12;

endpackage

// File: rtl/m_pte_check.sv
// Combinational decode of one Sv32 PTE: classifies it as a usable leaf,
// a pointer to the next level, or a page fault.
// Optional build macro: PTW_AD_FAULT_EN (fault leaves whose A/D bits are not set).
module m_pte_check
  import rvpc_mmu_pkg::*;
(
  input  logic [31:0] pte,
  input  logic        level,
  input  logic        store,
  output logic        valid_leaf,
  output logic        next_level,
  output logic        fault
);

  logic leaf;
  logic bad_enc;
  logic misaligned;
  logic dead_end;
  logic ad_fault;

`ifndef PTW_AD_FAULT_EN
  logic unused_ad;
  assign unused_ad = ^{store, pte[PTE_A], pte[PTE_D]};
`endif
  logic unused_bits;
  assign unused_bits = ^{pte[31:20], pte[9:8], pte[PTE_G], pte[PTE_U]};

  // Classify the PTE; level=1 means the first (superpage) level.
  always_comb begin
    leaf       = pte[PTE_R] | pte[PTE_X];
    bad_enc    = !pte[PTE_V] | (!pte[PTE_R] & pte[PTE_W]);
    misaligned = leaf & level & (pte[PTE_PPN_LSB +: 10] != 10'd0);
    dead_end   = !leaf & !level;
    ad_fault   = 1'b0;
`ifdef PTW_AD_FAULT_EN
    ad_fault   = leaf & (!pte[PTE_A] | (store & !pte[PTE_D]));
`endif
    fault      = bad_enc | misaligned | dead_end | ad_fault;
    next_level = !fault & !leaf;
    valid_leaf = !fault & leaf;
  end

endmodule

// File: rtl/m_ptw_sv32.sv
// Sv32 two-level hardware page-table walker feeding the translation cache.
// Optional build macro: PTW_AD_FAULT_EN (handled inside m_pte_check).
module m_ptw_sv32
  import rvpc_mmu_pkg::*;
#(
  parameter int VPN_W = 20,
  parameter int PPN_W = 20,
  parameter int FLG_W = 8
) (
  input  logic                   CLK,
  input  logic                   RST_X,
  input  logic [31:0]            i_satp,
  input  logic                   i_req,
  input  logic [31:0]            i_vaddr,
  input  logic                   i_store,
  input  logic                   i_flush,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_fault,
  output logic [PPN_W-1:0]       o_ppn,
  output logic [FLG_W-1:0]       o_flags,
  output logic                   o_mem_req,
  output logic [31:0]            o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_rdata,
  output logic                   o_fill_we,
  output logic [VPN_W-1:0]       o_fill_vpn,
  output logic [PPN_W+FLG_W-1:0] o_fill_data
);

  ptw_state_e       state_q, state_d;
  logic [19:0]      vpn_q, vpn_d;
  logic             store_q, store_d;
  logic [19:0]      root_q, root_d;
  logic             bare_q, bare_d;
  logic             abort_q, abort_d;
  logic [19:0]      l0_base_q, l0_base_d;
  logic [19:0]      ppn_q, ppn_d;
  logic [7:0]       flags_q, flags_d;
  logic             fault_q, fault_d;

  logic             chk_valid_leaf;
  logic             chk_next_level;
  logic             chk_fault;
  logic [31:0]      l1_addr;
  logic [31:0]      l0_addr;

  logic unused_in;
  assign unused_in = ^{i_satp[30:20], i_vaddr[11:0], i_mem_rdata[31:30]};

  m_pte_check u_pte_check (
    .pte        (i_mem_rdata),
    .level      (state_q == PTW_L1),
    .store      (store_q),
    .valid_leaf (chk_valid_leaf),
    .next_level (chk_next_level),
    .fault      (chk_fault)
  );

  // PTE addresses: page base plus 4-byte index, wrapping at 32 bits.
  always_comb begin
    l1_addr = (32'(root_q) << PAGE_SHIFT) + 32'({vpn_q[19:10], 2'b00});
    l0_addr = (32'(l0_base_q) << PAGE_SHIFT) + 32'({vpn_q[9:0], 2'b00});
  end

  // Walk sequencing: capture on accept, issue PTE reads, resolve on ack.
  always_comb begin
    state_d   = state_q;
    vpn_d     = vpn_q;
    store_d   = store_q;
    root_d    = root_q;
    bare_d    = bare_q;
    abort_d   = abort_q;
    l0_base_d = l0_base_q;
    ppn_d     = ppn_q;
    flags_d   = flags_q;
    fault_d   = fault_q;
    case (state_q)
      PTW_IDLE: begin
        abort_d = 1'b0;
        if (i_req && !i_flush) begin
          vpn_d   = i_vaddr[31:12];
          store_d = i_store;
          root_d  = i_satp[19:0];
          fault_d = 1'b0;
          flags_d = 8'h00;
          if (i_satp[SATP_MODE_BIT]) begin
            bare_d  = 1'b0;
            state_d = PTW_L1;
          end else begin
            bare_d  = 1'b1;
            ppn_d   = i_vaddr[31:12];
            state_d = PTW_RESP;
          end
        end
      end
      PTW_L1, PTW_L0: begin
        if (i_flush) abort_d = 1'b1;
        if (i_mem_ack) begin
          flags_d = i_mem_rdata[7:0];
          if (abort_q || i_flush) begin
            state_d = PTW_IDLE;
          end else if (chk_fault) begin
            fault_d = 1'b1;
            ppn_d   = 20'h0;
            state_d = PTW_RESP;
          end else if (chk_next_level) begin
            l0_base_d = i_mem_rdata[29:10];
            state_d   = PTW_L0;
          end else if (chk_valid_leaf) begin
            if (state_q == PTW_L1) ppn_d = {i_mem_rdata[29:20], vpn_q[9:0]};
            else                   ppn_d = i_mem_rdata[29:10];
            state_d = PTW_RESP;
          end
        end
      end
      default: state_d = PTW_IDLE;
    endcase
  end

  // Walker state registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= PTW_IDLE;
      vpn_q     <= '0;
      store_q   <= 1'b0;
      root_q    <= '0;
      bare_q    <= 1'b0;
      abort_q   <= 1'b0;
      l0_base_q <= '0;
      ppn_q     <= '0;
      flags_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      vpn_q     <= vpn_d;
      store_q   <= store_d;
      root_q    <= root_d;
      bare_q    <= bare_d;
      abort_q   <= abort_d;
      l0_base_q <= l0_base_d;
      ppn_q     <= ppn_d;
      flags_q   <= flags_d;
      fault_q   <= fault_d;
    end
  end

  // Outputs decode from state; result fields read zero outside a done cycle.
  always_comb begin
    o_busy      = (state_q != PTW_IDLE);
    o_mem_req   = (state_q == PTW_L1) || (state_q == PTW_L0);
    o_mem_addr  = 32'h0;
    if (state_q == PTW_L1) o_mem_addr = l1_addr;
    if (state_q == PTW_L0) o_mem_addr = l0_addr;
    o_done      = (state_q == PTW_RESP) && !i_flush;
    o_fault     = o_done && fault_q;
    o_ppn       = o_done ? PPN_W'(ppn_q) : '0;
    o_flags     = o_done ? FLG_W'(flags_q) : '0;
    o_fill_we   = o_done && !fault_q && !bare_q;
    o_fill_vpn  = o_done ? VPN_W'(vpn_q) : '0;
    o_fill_data = {o_ppn, o_flags};
  end

endmodule
